// File: rtl/sprite_palette_engine.sv
// -----------------------------------------------------------------------------
// sprite_palette_engine
// Multi-palette colour lookup for sprite/background pixels. One RAM holds
// NUM_PAL palettes of 2**INDEX_W entries, each a 12-bit {R,G,B} 4:4:4 colour.
// Pixels go through a fixed 2-cycle read pipeline. The output colour is scaled
// by a frame-stepped brightness level (fade in / fade out) or forced to white
// during a flash. A transparency flag marks the chroma-key index.
//
// Ports
//   Clk, Reset_n         clock (rising edge) and asynchronous active-low reset
//   pix_valid            index / pal_sel valid this cycle
//   index, pal_sel       pixel colour index and palette select
//   rgb_valid            red/green/blue/transparent valid (2 cycles after pix_valid)
//   red, green, blue     output colour after fade / flash
//   transparent          pixel index == TRANSP_INDEX
//   wr_en, wr_addr,      palette RAM write port, address = {palette, index},
//   wr_data              data = {R,G,B}
//   frame_tick           one-cycle pulse per frame, steps the fade engine
//   fade_cmd             00 none, 01 fade out, 10 fade in, 11 flash
//   fade_busy            fade engine not idle
//   level                current brightness 0..16 (16 = unity)
// -----------------------------------------------------------------------------
module sprite_palette_engine #(
    parameter int    NUM_PAL      = 4,
    parameter int    INDEX_W      = 4,
    parameter int    TRANSP_INDEX = 15,
    parameter int    FADE_STEP    = 1,
    parameter int    FLASH_FRAMES = 8,
    parameter string INIT_FILE    = "",
    localparam int   PAL_W        = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    // pixel in
    input  logic                     pix_valid,
    input  logic [INDEX_W-1:0]       index,
    input  logic [PAL_W-1:0]         pal_sel,
    // pixel out
    output logic                     rgb_valid,
    output logic [3:0]               red,
    output logic [3:0]               green,
    output logic [3:0]               blue,
    output logic                     transparent,
    // palette RAM write port
    input  logic                     wr_en,
    input  logic [PAL_W+INDEX_W-1:0] wr_addr,
    input  logic [11:0]              wr_data,
    // fade / flash engine
    input  logic                     frame_tick,
    input  logic [1:0]               fade_cmd,
    output logic                     fade_busy,
    output logic [4:0]               level
);

    // A single palette needs no select bit in the RAM address.
    localparam int ADDR_W = $clog2(NUM_PAL) + INDEX_W;
    localparam int DEPTH  = NUM_PAL << INDEX_W;
    localparam int CNT_W  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2,
        FLASH    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Palette RAM (synchronous, read-first)
    // ------------------------------------------------------------------
    logic [11:0]       mem [DEPTH];
    logic [11:0]       rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wa;

    assign rd_addr = ADDR_W'({pal_sel, index});
    assign wa      = ADDR_W'(wr_addr);

    // NOTE: the RAM and its read register have no reset, so they map onto
    // block RAM; rd_data is only consumed when the matching valid is set.
    // NOTE: non-blocking assignments make the read see the pre-write contents
    // when the same address is written and read on one edge (read-first).
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wa] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Fade / flash engine
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [4:0]       level_n;
    logic [CNT_W-1:0] flash_cnt, flash_cnt_n;
    logic [5:0]       level_dn, level_up;

    // 6-bit arithmetic so level + FADE_STEP (up to 32) cannot wrap.
    assign level_dn = ({1'b0, level} > 6'(FADE_STEP)) ? ({1'b0, level} - 6'(FADE_STEP)) : 6'd0;
    assign level_up = ({1'b0, level} + 6'(FADE_STEP) > 6'd16) ? 6'd16
                                                              : ({1'b0, level} + 6'(FADE_STEP));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            level     <= 5'd16;
            flash_cnt <= '0;
        end else begin
            state     <= state_n;
            level     <= level_n;
            flash_cnt <= flash_cnt_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n     = state;
        level_n     = level;
        flash_cnt_n = flash_cnt;
        unique case (state)
            IDLE: begin
                // A frame_tick in the command cycle is deliberately not applied.
                unique case (fade_cmd)
                    2'b01:   state_n = FADE_OUT;
                    2'b10:   state_n = FADE_IN;
                    2'b11: begin
                        state_n     = FLASH;
                        flash_cnt_n = '0;
                    end
                    default: state_n = IDLE;
                endcase
            end
            FADE_OUT: begin
                if (level == 5'd0) begin
                    state_n = IDLE;
                end else if (frame_tick) begin
                    level_n = level_dn[4:0];
                    if (level_dn == 6'd0) state_n = IDLE;
                end
            end
            FADE_IN: begin
                if (level == 5'd16) begin
                    state_n = IDLE;
                end else if (frame_tick) begin
                    level_n = level_up[4:0];
                    if (level_up == 6'd16) state_n = IDLE;
                end
            end
            FLASH: begin
                if (frame_tick) begin
                    if (flash_cnt == CNT_W'(FLASH_FRAMES - 1)) begin
                        state_n = IDLE;
                    end else begin
                        flash_cnt_n = flash_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign fade_busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Pixel pipeline
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s1_transp;

    // (c * level) >> 4; the product never exceeds 8 bits since level <= 16.
    function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lv);
        logic [8:0] p;
        p = {5'd0, c} * {4'd0, lv};
        return p[7:4];
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid    <= 1'b0;
            s1_transp   <= 1'b0;
            rgb_valid   <= 1'b0;
            red         <= 4'd0;
            green       <= 4'd0;
            blue        <= 4'd0;
            transparent <= 1'b0;
        end else begin
            s1_valid  <= pix_valid;
            s1_transp <= (index == INDEX_W'(TRANSP_INDEX));
            rgb_valid <= s1_valid;
            // Outputs hold their last pixel while no new one arrives.
            if (s1_valid) begin
                transparent <= s1_transp;
                if (state == FLASH) begin
                    red   <= 4'hF;
                    green <= 4'hF;
                    blue  <= 4'hF;
                end else begin
                    red   <= scale(rd_data[11:8], level);
                    green <= scale(rd_data[7:4],  level);
                    blue  <= scale(rd_data[3:0],  level);
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_engine.sv
// -----------------------------------------------------------------------------
// tb_sprite_palette_engine
// Directed test of sprite_palette_engine with default parameters: palette
// write/read latency, read-first collision, transparency streaming, fade out,
// fade in, flash and asynchronous reset during a fade.
// -----------------------------------------------------------------------------
module tb_sprite_palette_engine;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [3:0]  index;
    logic [1:0]  pal_sel;
    logic        rgb_valid;
    logic [3:0]  red, green, blue;
    logic        transparent;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [11:0] wr_data;
    logic        frame_tick;
    logic [1:0]  fade_cmd;
    logic        fade_busy;
    logic [4:0]  level;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_palette_engine dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .pix_valid   (pix_valid),
        .index       (index),
        .pal_sel     (pal_sel),
        .rgb_valid   (rgb_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .transparent (transparent),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .frame_tick  (frame_tick),
        .fade_cmd    (fade_cmd),
        .fade_busy   (fade_busy),
        .level       (level)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] pal, input logic [3:0] idx, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_addr = {pal, idx};
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    // Issue one pixel and wait the 2-cycle latency; outputs are then valid.
    task automatic read_pix(input logic [1:0] pal, input logic [3:0] idx);
        pix_valid = 1'b1;
        pal_sel   = pal;
        index     = idx;
        step();
        pix_valid = 1'b0;
        step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic command(input logic [1:0] cmd);
        fade_cmd = cmd;
        step();
        fade_cmd = 2'b00;
    endtask

    initial begin
        Reset_n    = 1'b0;
        pix_valid  = 1'b0;
        index      = '0;
        pal_sel    = '0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        frame_tick = 1'b0;
        fade_cmd   = 2'b00;

        // ---------------- reset state ----------------
        #12;
        check("rst_rgb_valid", rgb_valid, 0);
        check("rst_rgb",       {red, green, blue}, 12'h000);
        check("rst_transp",    transparent, 0);
        check("rst_busy",      fade_busy, 0);
        check("rst_level",     level, 16);
        #1 Reset_n = 1'b1;
        step();

        // ---------------- basic write / read, latency 2 ----------------
        wr(2'd1, 4'd3, 12'hD84);
        pix_valid = 1'b1; pal_sel = 2'd1; index = 4'd3;
        step();
        pix_valid = 1'b0;
        check("lat1_valid_low", rgb_valid, 0);
        step();
        check("rd_valid",  rgb_valid, 1);
        check("rd_rgb",    {red, green, blue}, 12'hD84);
        check("rd_transp", transparent, 0);
        step();
        check("hold_valid", rgb_valid, 0);
        check("hold_rgb",   {red, green, blue}, 12'hD84);

        // ---------------- read-first collision ----------------
        wr(2'd2, 4'd5, 12'h442);
        wr_en = 1'b1; wr_addr = {2'd2, 4'd5}; wr_data = 12'hFFF;
        pix_valid = 1'b1; pal_sel = 2'd2; index = 4'd5;
        step();
        wr_en = 1'b0;          // second read of the same address, one cycle later
        step();
        pix_valid = 1'b0;
        check("rf_old", {red, green, blue}, 12'h442);
        step();
        check("rf_new", {red, green, blue}, 12'hFFF);

        // ---------------- transparency stream 14,15,0 ----------------
        wr(2'd0, 4'd14, 12'h123);
        wr(2'd0, 4'd15, 12'h456);
        wr(2'd0, 4'd0,  12'h789);
        wr(2'd3, 4'd1,  12'hFB8);
        pix_valid = 1'b1; pal_sel = 2'd0; index = 4'd14;
        step();
        index = 4'd15;
        step();
        check("st0_transp", transparent, 0);
        check("st0_rgb",    {red, green, blue}, 12'h123);
        index = 4'd0;
        step();
        pix_valid = 1'b0;
        check("st1_transp", transparent, 1);
        check("st1_rgb",    {red, green, blue}, 12'h456);
        check("st1_valid",  rgb_valid, 1);
        step();
        check("st2_transp", transparent, 0);
        check("st2_rgb",    {red, green, blue}, 12'h789);

        // ---------------- fade out ----------------
        frame_tick = 1'b1;     // tick in the command cycle must not step
        command(2'b01);
        frame_tick = 1'b0;
        check("fo_busy_start",  fade_busy, 1);
        check("fo_level_start", level, 16);
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("fo_level_%0d", k), level, 32'(16 - k));
            check($sformatf("fo_busy_%0d", k),  fade_busy, (k < 16) ? 1 : 0);
            if (k == 4) begin
                command(2'b11);    // ignored while busy
                check("fo_ignore_busy",  fade_busy, 1);
                check("fo_ignore_level", level, 12);
            end
            if (k == 8) begin
                read_pix(2'd3, 4'd1);
                check("fo_scaled_l8", {red, green, blue}, 12'h754);
            end
        end
        read_pix(2'd3, 4'd1);
        check("fo_black", {red, green, blue}, 12'h000);
        step();
        check("fo_level_persist", level, 0);

        // ---------------- fade in ----------------
        command(2'b10);
        for (int k = 1; k <= 16; k++) tick();
        check("fi_level", level, 16);
        check("fi_busy",  fade_busy, 0);

        // fade in at level 16 leaves on the next edge
        command(2'b10);
        check("fi16_busy",  fade_busy, 1);
        step();
        check("fi16_idle",  fade_busy, 0);
        check("fi16_level", level, 16);

        // ---------------- flash ----------------
        command(2'b11);
        check("fl_busy_start", fade_busy, 1);
        read_pix(2'd0, 4'd15);
        check("fl_rgb",    {red, green, blue}, 12'hFFF);
        check("fl_transp", transparent, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("fl_busy_%0d", k), fade_busy, (k < 8) ? 1 : 0);
        end
        check("fl_level", level, 16);
        read_pix(2'd3, 4'd1);
        check("fl_after_rgb", {red, green, blue}, 12'hFB8);

        // ---------------- async reset during fade in ----------------
        command(2'b01);
        for (int k = 1; k <= 16; k++) tick();
        check("rs_level0", level, 0);
        command(2'b10);
        for (int k = 1; k <= 5; k++) tick();
        check("rs_level5", level, 5);
        check("rs_busy5",  fade_busy, 1);
        read_pix(2'd3, 4'd1);
        check("rs_scaled_l5", {red, green, blue}, 12'h432);
        check("rs_valid_pre", rgb_valid, 1);
        #1 Reset_n = 1'b0;     // between clock edges
        #1;
        check("rs_level",  level, 16);
        check("rs_busy",   fade_busy, 0);
        check("rs_valid",  rgb_valid, 0);
        check("rs_rgb",    {red, green, blue}, 12'h000);
        check("rs_transp", transparent, 0);
        #1 Reset_n = 1'b1;
        step();
        check("rs_after_level", level, 16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
